// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: word type, fetch FSM states, reset PC and the
// IF/ID pipeline register layout.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } fetch_state;

  localparam lc3b_word RESET_PC = 16'h0000;

  typedef struct packed {
    logic     valid;
    lc3b_word ir;
    lc3b_word pc;
  } if_id_t;

endpackage

// File: rtl/register.sv
// Generic loadable register with synchronous active-high clear.
module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch stage: drives instruction memory, fills the IF/ID
// register, absorbs ID stalls and redirects. FETCH_PERF_CNT_EN adds a stall counter.
module fetch_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_resp,
  input  lc3b_word    imem_rdata,
  output logic        imem_read,
  output lc3b_word    imem_address,
  input  logic        stall_in,
  input  logic        redirect,
  input  lc3b_word    redirect_pc,
  output lc3b_word    ir_ID,
  output lc3b_word    pc_ID,
  output logic        valid_ID,
  output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stall_cnt
`endif
);

  fetch_state state, state_next;
  lc3b_word   pc, pc_next, pc_plus2, target;
  lc3b_word   squash_addr, squash_addr_next;
  lc3b_word   hold_buf, hold_buf_next;
  if_id_t     if_id_d, if_id_q;
  logic       if_id_ld;

  assign pc_plus2 = pc + 16'd2;
  assign target   = redirect_pc & 16'hFFFE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash_addr <= RESET_PC;
      hold_buf    <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      squash_addr <= squash_addr_next;
      hold_buf    <= hold_buf_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    squash_addr_next = squash_addr;
    hold_buf_next    = hold_buf;
    if_id_ld         = 1'b0;
    if_id_d          = if_id_q;
    imem_read        = 1'b0;
    imem_address     = pc;

    unique case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem_read = 1'b1;
        if (redirect) begin
          // Unanswered read must still be drained at its original address.
          state_next       = imem_resp ? FETCH : SQUASH;
          squash_addr_next = pc;
        end else if (imem_resp) begin
          pc_next = pc_plus2;
          if (stall_in) begin
            hold_buf_next = imem_rdata;
            state_next    = HOLD;
          end else begin
            if_id_ld = 1'b1;
            if_id_d  = '{valid: 1'b1, ir: imem_rdata, pc: pc_plus2};
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next = FETCH;
        end else if (!stall_in) begin
          // pc already advanced past the buffered word, so it is its pc_ID.
          if_id_ld   = 1'b1;
          if_id_d    = '{valid: 1'b1, ir: hold_buf, pc: pc};
          state_next = FETCH;
        end
      end
      SQUASH: begin
        imem_read    = 1'b1;
        imem_address = squash_addr;
        if (imem_resp) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    if (redirect) begin
      pc_next       = target;
      hold_buf_next = '0;
    end

    // Flush on redirect; bubble when ID consumed and nothing new arrived.
    if (redirect || (!stall_in && !if_id_ld)) begin
      if_id_ld      = 1'b1;
      if_id_d.valid = 1'b0;
    end

    if (reset) imem_read = 1'b0;
    imem_address[0] = 1'b0;
  end

  register #(.WIDTH($bits(if_id_t))) if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (if_id_ld),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign ir_ID      = if_id_q.ir;
  assign pc_ID      = if_id_q.pc;
  assign valid_ID   = if_id_q.valid;
  assign fetch_busy = (state != FETCH) || !imem_resp;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) fetch_stall_cnt <= '0;
    else if (fetch_busy || state == HOLD) fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory responder with variable latency,
// reference instruction stream in a queue, monitor popping on each consumed IF/ID.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        stall_in = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] ir_ID, pc_ID;
  logic        valid_ID, fetch_busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .stall_in     (stall_in),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ir_ID        (ir_ID),
    .pc_ID        (pc_ID),
    .valid_ID     (valid_ID),
    .fetch_busy   (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int consumed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents
  logic [15:0] mem_ovr [logic [15:0]];
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Reference stream: program order from the last reset/redirect target
  typedef struct { logic [15:0] ir; logic [15:0] pc; } exp_t;
  exp_t        sb[$];
  logic [15:0] fill_addr;

  function automatic void topup();
    exp_t e;
    while (sb.size() < 16) begin
      e.ir = mem_word(fill_addr);
      e.pc = fill_addr + 16'd2;
      sb.push_back(e);
      fill_addr = fill_addr + 16'd2;
    end
  endfunction

  function automatic void restart(input logic [15:0] a);
    sb.delete();
    fill_addr = a;
    topup();
  endfunction

  logic flush_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      restart(16'h0000);
      flush_seen = 1'b1;
    end else begin
      if (flush_seen) check("valid_after_flush", {31'd0, valid_ID}, 32'd0);
      flush_seen = 1'b0;
      if (redirect) begin
        restart(redirect_pc & 16'hFFFE);
        flush_seen = 1'b1;
      end else if (valid_ID && !stall_in) begin
        e = sb.pop_front();
        check("ifid_ir", {16'd0, ir_ID}, {16'd0, e.ir});
        check("ifid_pc", {16'd0, pc_ID}, {16'd0, e.pc});
        consumed++;
        topup();
      end
    end
  end

  // Driver + memory responder
  logic        tracking = 1'b0;
  int          left = 0;
  int          lat_fixed = 1;
  logic [15:0] taddr = '0;
  logic        pend_valid = 1'b0;
  logic [15:0] pend_addr = '0;
  logic        junk_once = 1'b0;

  task automatic step(input logic rst, input logic st, input logic rd, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    reset = rst; stall_in = st; redirect = rd; redirect_pc = rpc;
    #1;
    if (imem_resp) begin imem_resp = 1'b0; tracking = 1'b0; end
    if (reset) begin
      check("read_in_reset", {31'd0, imem_read}, 32'd0);
      tracking = 1'b0;
    end else if (tracking) begin
      check("read_held", {15'd0, imem_read, imem_address}, {15'd0, 1'b1, taddr});
      left--;
      if (left == 0) begin imem_resp = 1'b1; imem_rdata = mem_word(taddr); end
    end else if (imem_read) begin
      check("addr_even", {31'd0, imem_address[0]}, 32'd0);
      if (pend_valid) begin
        check("next_fetch_addr", {16'd0, imem_address}, {16'd0, pend_addr});
        pend_valid = 1'b0;
      end
      tracking = 1'b1;
      taddr    = imem_address;
      left     = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
      left--;
      if (left == 0) begin imem_resp = 1'b1; imem_rdata = mem_word(taddr); end
    end else if (junk_once) begin
      imem_resp  = 1'b1;
      imem_rdata = 16'hDEAD;
      junk_once  = 1'b0;
    end
    if (rst) begin pend_valid = 1'b1; pend_addr = 16'h0000; end
    else if (rd) begin pend_valid = 1'b1; pend_addr = rpc & 16'hFFFE; end
  endtask

  initial begin
    mem_ovr[16'h0000] = 16'h1234;
    mem_ovr[16'h0002] = 16'h5678;
    mem_ovr[16'h0006] = 16'hABCD;
    restart(16'h0000);

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_ir", {16'd0, ir_ID}, 32'd0);
    check("rst_pc", {16'd0, pc_ID}, 32'd0);
    check("rst_valid", {31'd0, valid_ID}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_cnt", fetch_stall_cnt, 32'd0);
`endif

    // Straight-line fetch, 1-cycle memory; a stray response lands in IDLE
    lat_fixed = 1;
    junk_once = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("addr_seq0", {16'd0, imem_address}, 32'h0000);
    step(0, 0, 0, 0);
    check("addr_seq1", {16'd0, imem_address}, 32'h0002);
    check("first_ir", {16'd0, ir_ID}, 32'h1234);
    check("first_pc", {16'd0, pc_ID}, 32'h0002);
    step(0, 0, 0, 0);
    check("second_ir", {16'd0, ir_ID}, 32'h5678);
    check("second_pc", {16'd0, pc_ID}, 32'h0004);

    // Stall while ABCD returns from address 6
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("hold_no_read", {31'd0, imem_read}, 32'd0);
    check("hold_busy", {31'd0, fetch_busy}, 32'd1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("released_ir", {16'd0, ir_ID}, 32'hABCD);
    check("released_pc", {16'd0, pc_ID}, 32'h0008);

    // Redirect to 3001 during a 4-cycle read
    lat_fixed = 4;
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'h3001);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);

    // Redirect + response + stall in one cycle
    lat_fixed = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 1, 16'h4444);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // PC wrap from FFFE
    step(0, 0, 1, 16'hFFFE);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("wrap_pc_ID", {16'd0, pc_ID}, 32'h0000);
    check("wrap_next_addr", {16'd0, imem_address}, 32'h0000);

    // Reset while a read is outstanding
    lat_fixed = 4;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_cnt_after_reset", fetch_stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

    // Randomized traffic
    lat_fixed = 0;
    for (int i = 0; i < 4000; i++) begin
      logic        r, s, d;
      logic [15:0] t;
      r = ($urandom_range(0, 499) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step(r, s, d, t);
    end
    check("progress", {31'd0, consumed > 400}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port reset.
REQ-002 SHALL have ports:
  - clk  in  1  rising-edge clock
  - reset  in  1  synchronous, active-high reset
  - imem_resp  in  1  instruction memory has completed the current read
  - imem_rdata  in  16  instruction word, valid when imem_resp=1
  - imem_read  out  1  read request
  - imem_address  out  16  fetch address
  - stall_in  in  1  ID/EX load withheld, so hold IF/ID
  - redirect  in  1  taken branch/JMP/TRAP, so flush and refetch
  - redirect_pc  in  16  target address
  - ir_ID  out  16  IF/ID instruction register
  - pc_ID  out  16  IF/ID PC (fetch address + 2)
  - valid_ID  out  1  IF/ID holds a real instruction
  - fetch_busy  out  1  high whenever state is not FETCH or a read is outstanding without response

Function
REQ-003 SHALL implement states IDLE, FETCH, HOLD, SQUASH, encoded as a package enum.
REQ-004 IDLE: imem_read=0; next state is FETCH unconditionally.
REQ-005 FETCH: imem_read=1 and imem_address=pc.
  - imem_address SHALL stay stable until imem_resp.
  - imem_address[0] SHALL always be 0.
REQ-006 FETCH with imem_resp=1, stall_in=0, redirect=0:
  - ir_ID<=imem_rdata; pc_ID<=pc+2; valid_ID<=1; pc<=pc+2; state stays FETCH.
  - Back-to-back 1-cycle responses SHALL give one instruction per cycle.
REQ-007 FETCH with imem_resp=1, stall_in=1, redirect=0:
  - imem_rdata goes to a one-entry holding buffer; pc<=pc+2; state to HOLD.
  - IF/ID is unchanged.
REQ-008 HOLD: imem_read=0. When stall_in=0:
  - IF/ID loads from the buffer with valid_ID<=1.
  - State goes to FETCH.
REQ-009 While stall_in=1 and redirect=0, ir_ID, pc_ID and valid_ID SHALL hold their values.
REQ-010 Redirect has priority over everything else. On a cycle with redirect=1:
  - pc<={redirect_pc[15:1],1'b0}
  - valid_ID<=0 (flush), regardless of stall_in
  - holding buffer discarded
REQ-011 Redirect arriving while a read is outstanding (FETCH, imem_resp=0):
  - State goes to SQUASH.
  - imem_read stays 1 with the old address until imem_resp.
  - The returned word is discarded, then state goes to FETCH at the new pc.
REQ-012 Redirect coinciding with imem_resp in FETCH: the data is discarded and the next state is FETCH at redirect_pc.
REQ-013 Redirect in SQUASH: pc is updated to the newest target and state stays SQUASH.
REQ-014 Redirect in HOLD: state goes to FETCH at redirect_pc.
REQ-015 pc arithmetic SHALL be 16-bit modulo: 16'hFFFE+2=16'h0000, with no carry out.
REQ-016 Latency: an instruction is visible on ir_ID the cycle after imem_resp when not stalled.

Reset
REQ-017 During reset=1, imem_read SHALL be 0.
REQ-018 On the reset edge:
  - state<=IDLE; pc<=16'h0000
  - ir_ID<=0; pc_ID<=0; valid_ID<=0
  - holding buffer cleared
REQ-019 Reset mid-read SHALL abandon the request without waiting for imem_resp. Any late imem_resp in IDLE SHALL be ignored.

Configuration
REQ-020 With macro FETCH_PERF_CNT_EN defined:
  - Add output fetch_stall_cnt (32 bits).
  - It counts cycles where fetch_busy=1 or state=HOLD.
  - Reset value 0; wraps at 2^32.
REQ-021 Without FETCH_PERF_CNT_EN, the port and counter SHALL not exist. All other behaviour is identical.

Structure
REQ-022 lc3b_types SHALL hold:
  - the fetch_state enum
  - the reset PC constant
  - lc3b_word (used for all 16-bit ports)
REQ-023 IF/ID storage SHALL use the existing parameterized register module. No new sub-module is required.

Verification
REQ-024 Reset, then 1-cycle imem_resp returning 16'h1234, 16'h5678:
  - imem_address sequence is 0000, 0002.
  - ir_ID/pc_ID are 1234/0002, then 5678/0004.
REQ-025 stall_in=1 for 3 cycles while imem_resp returns 16'hABCD:
  - IF/ID is frozen and state is HOLD.
  - After release, ir_ID=ABCD exactly once, with no duplicate or lost instruction.
REQ-026 redirect to 16'h3001 during an outstanding read with a 4-cycle memory latency:
  - Old address is held until response; that word is never visible.
  - Next address is 3000; valid_ID=0 in between.
REQ-027 redirect with imem_resp and stall_in all in the same cycle: valid_ID=0 next cycle and the next fetch is at redirect_pc.
REQ-028 Start at pc=FFFE via redirect: pc_ID=0000 and the next fetch address is 0000.
REQ-029 Assert reset while waiting for imem_resp: imem_read=0 next cycle, then a fetch at 0000 after IDLE. With FETCH_PERF_CNT_EN, the counter is 0 after reset.
